// File: rtl/resp_serializer_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | resp_serializer_if                                                     |
// | FIFO-read and NoC valid/ready signals of the response serializer.      |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
interface resp_serializer_if #(
  parameter int FLIT_WIDTH  = 16,
  parameter int TOTAL_FLITS = 4
);
  logic [FLIT_WIDTH*TOTAL_FLITS-1:0] fifo_din;
  logic                              fifo_empty;
  logic                              fifo_rreq;
  logic [FLIT_WIDTH-1:0]             o_flit;
  logic                              o_valid;
  logic                              o_head;
  logic                              o_tail;
  logic                              i_ready;
  logic                              o_pkt_done;
  logic                              busy;

  // The serializer drives the NoC, so it is the master side.
  modport master (
    input  fifo_din, fifo_empty, i_ready,
    output fifo_rreq, o_flit, o_valid, o_head, o_tail, o_pkt_done, busy
  );

  modport slave (
    output fifo_din, fifo_empty, i_ready,
    input  fifo_rreq, o_flit, o_valid, o_head, o_tail, o_pkt_done, busy
  );
endinterface
`default_nettype wire

// File: rtl/resp_serializer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | resp_serializer                                                        |
// | Pops a response packet from the FIFO and streams it as head/body/tail  |
// | flits over valid/ready. Option: RESP_SERIALIZER_BACK_TO_BACK_EN.       |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module resp_serializer #(
  parameter int FLIT_WIDTH  = 16,
  parameter int TOTAL_FLITS = 4
) (
  input  wire logic         clk,
  input  wire logic         resetn,
  resp_serializer_if.master bus
);
  localparam int                BEAT_W    = $clog2(TOTAL_FLITS);
  localparam int                PKT_W     = FLIT_WIDTH * TOTAL_FLITS;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(TOTAL_FLITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [PKT_W-1:0]  buf_q, buf_d;

  logic [FLIT_WIDTH-1:0] flit_mux [TOTAL_FLITS];
  logic                  rreq;
  logic                  valid;
  logic [FLIT_WIDTH-1:0] flit;
  logic                  head;
  logic                  tail;
  logic                  pkt_done;

  for (genvar k = 0; k < TOTAL_FLITS; k++) begin : g_flit_unpack
    assign flit_mux[k] = buf_q[k*FLIT_WIDTH +: FLIT_WIDTH];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      beat_q  <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    buf_d    = buf_q;
    rreq     = 1'b0;
    valid    = 1'b0;
    flit     = '0;
    head     = 1'b0;
    tail     = 1'b0;
    pkt_done = 1'b0;

    case (state_q)
      IDLE: begin
        // Gated by resetn so no pop can be issued while reset is held.
        rreq = resetn && !bus.fifo_empty;
        if (rreq) begin
          state_d = LOAD;
        end
      end

      LOAD: begin
        buf_d   = bus.fifo_din;
        beat_d  = '0;
        state_d = SEND;
      end

      SEND: begin
        valid = 1'b1;
        flit  = flit_mux[beat_q];
        head  = (beat_q == '0);
        tail  = (beat_q == LAST_BEAT);
        if (bus.i_ready) begin
          if (tail) begin
            pkt_done = 1'b1;
`ifdef RESP_SERIALIZER_BACK_TO_BACK_EN
            if (!bus.fifo_empty) begin
              rreq    = 1'b1;
              state_d = LOAD;
            end else begin
              state_d = IDLE;
            end
`else
            state_d = IDLE;
`endif
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.fifo_rreq  = rreq;
  assign bus.o_valid    = valid;
  assign bus.o_flit     = flit;
  assign bus.o_head     = head;
  assign bus.o_tail     = tail;
  assign bus.o_pkt_done = pkt_done;
  assign bus.busy       = (state_q != IDLE);
endmodule
`default_nettype wire

// File: doc/resp_serializer.md
# resp_serializer

- Transmit side of the network interface.
- Pops one response packet from the response FIFO and sends it onto the NoC as a head/body/tail sequence of flits, one flit per accepted beat.
- Uses a valid/ready handshake toward the NoC.
- Counterpart to the request-side sampler, which assembles incoming flits into packets and writes them to the request FIFO.

## Interface
Parameters:
- FLIT_WIDTH, 16, width of one flit.
- TOTAL_FLITS, 4, flits per packet (head + TOTAL_FLITS-2 body + tail); legal range 2..16.
- BEAT_W, $clog2(TOTAL_FLITS), beat counter width (derived, not overridden).

Ports (clock and reset use the codebase names; reset is asynchronous, active-low):
- clk  in  1  single clock; all state updates on posedge.
- resetn  in  1  asynchronous active-low reset.
- fifo_din  in  FLIT_WIDTH*TOTAL_FLITS  packet read from FIFO; flit k occupies bits [k*FLIT_WIDTH +: FLIT_WIDTH]; flit 0 = head, flit TOTAL_FLITS-1 = tail.
- fifo_empty  in  1  response FIFO empty.
- fifo_rreq  out  1  FIFO pop; fifo_din is valid on the cycle after fifo_rreq.
- o_flit  out  FLIT_WIDTH  current flit to NoC.
- o_valid  out  1  o_flit is valid.
- o_head  out  1  current flit is the head (beat 0).
- o_tail  out  1  current flit is the tail (beat TOTAL_FLITS-1).
- i_ready  in  1  NoC accepts the flit on this cycle when o_valid=1.
- o_pkt_done  out  1  one-cycle pulse on the cycle the tail flit is accepted.
- busy  out  1  high in every state except IDLE.

## Operation
States:
- IDLE
  - fifo_rreq = !fifo_empty.
  - If fifo_rreq=1, go to LOAD.
- LOAD
  - Capture fifo_din into the packet buffer.
  - Clear beat to 0.
  - Go to SEND.
- SEND
  - Outputs: o_valid=1; o_flit = buffer flit[beat]; o_head = (beat==0); o_tail = (beat==TOTAL_FLITS-1).
  - On o_valid && i_ready with beat < TOTAL_FLITS-1: beat <= beat+1.
  - On o_valid && i_ready with beat == TOTAL_FLITS-1: o_pkt_done=1, then go to IDLE (see Configuration for the back-to-back option).
  - On o_valid && !i_ready: hold. beat, buffer, o_flit, o_head and o_tail stay unchanged, and o_valid is never withdrawn.
- Default branch: go to IDLE.

Rules:
- fifo_rreq is asserted only in IDLE, or on the tail-accept cycle when the back-to-back option is enabled. It is never asserted while fifo_empty=1.
- At most one pop is outstanding per packet; the buffer is never overwritten mid-packet.
- When o_valid=0, o_flit, o_head and o_tail are all 0.
- The buffer is a flop array of FLIT_WIDTH*TOTAL_FLITS bits. The beat counter never exceeds TOTAL_FLITS-1; there is no wrap past the tail.
- fifo_empty changes while in SEND are ignored until the tail is accepted.
- Reset asserted mid-packet: immediately returns to IDLE with all outputs 0. The partially sent packet is discarded and not re-fetched, because its FIFO entry has already been popped.

## Timing
- Reset values: state IDLE, beat 0, buffer 0, o_valid 0, o_flit 0, o_head 0, o_tail 0, fifo_rreq 0, o_pkt_done 0, busy 0.
- Outputs are combinational decodes of registered state/beat/buffer; no input-to-output combinational path except i_ready->o_pkt_done and fifo_empty->fifo_rreq.
- Latency: fifo_empty falls with state IDLE on cycle N. fifo_rreq=1 on N, LOAD on N+1, head flit valid on N+2.
- With i_ready held high, the tail is accepted on N+1+TOTAL_FLITS.
- Packet period with continuous traffic: TOTAL_FLITS+2 cycles (macro off), TOTAL_FLITS+1 cycles (macro on).

## Configuration
- Macro: RESP_SERIALIZER_BACK_TO_BACK_EN.
- Defined:
  - On the tail-accept cycle, if fifo_empty=0, assert fifo_rreq in the same cycle and go directly to LOAD, skipping IDLE.
  - busy stays high.
  - If fifo_empty=1 on that cycle, go to IDLE.
- Undefined:
  - Always return to IDLE after the tail is accepted.
  - fifo_rreq is never asserted from SEND.

## Test plan
- Single packet, TOTAL_FLITS=4, fifo_din flits {0x1111 head, 0x2222, 0x3333, 0x4444 tail}, i_ready=1: exactly one fifo_rreq. o_flit is 0x1111, 0x2222, 0x3333, 0x4444 on cycles N+2..N+5. o_head is high only with 0x1111, o_tail only with 0x4444. o_pkt_done pulses on N+5.
- Backpressure: same packet, i_ready=0 for 3 cycles while beat=1. o_flit holds 0x2222 with o_valid=1 for those 3 cycles, then the sequence resumes. No flit is skipped or duplicated.
- FIFO empty: fifo_empty=1 for 20 cycles. fifo_rreq=0, o_valid=0, busy=0 throughout.
- Two queued packets, i_ready=1:
  - Macro off: head of packet 2 appears 6 cycles after head of packet 1.
  - Macro on: 5 cycles.
  - Exactly 2 pops in both cases.
- Reset mid-packet: resetn low for 1 cycle while beat=2. All outputs read 0 immediately. Next, with fifo_empty=0, a fresh pop follows and sends a full packet starting at the head.
- Simultaneous events: fifo_empty rises on the tail-accept cycle (macro on). No fifo_rreq is issued and the state returns to IDLE.
